// File: rtl/sequence_store_pkg.sv
// sequence_store_pkg: shared types and helpers for the sequence store.
// Contents: FSM state enum, index-width helper.
// Imported by sequence_store and seq_ram users.
package sequence_store_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    CHECK = 2'd2
  } state_t;

  // Width of a read/write index into a store of 'depth' entries.
  // Callers guarantee depth >= 2, so the result is at least 1.
  function automatic int seq_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/seq_ram.sv
// seq_ram: DEPTH x DATA_W register array, one synchronous write, one async read.
// Latency: write visible on the cycle after 'we'; read is combinational.
// Backpressure: none; a single shared address serves both write and read.
// Ports:
//   clk   - clock
//   we    - write enable (writes wdata to mem[addr] on the rising edge)
//   addr  - shared write/read address
//   wdata - write data
//   rdata - mem[addr], combinational
module seq_ram #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  // Contents are intentionally not reset; only 'length' in the parent
  // decides which entries are meaningful.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/sequence_store.sv
// sequence_store: append-only symbol sequence with valid/ready replay and player check.
// Latency: playback data one cycle after play_start accept; check result one cycle after chk_valid.
// Backpressure: out_data/out_last held while out_valid && !out_ready; check input has none.
// Ports:
//   clk, rst                   - clock, synchronous active-high reset
//   clear                      - empty the store, abort playback/check
//   wr_en, wr_data             - append one symbol (IDLE only, ignored when full)
//   full, length               - registered fill status
//   play_start                 - replay from index 0
//   out_valid/ready/data/last  - playback stream
//   chk_start                  - start check from index 0
//   chk_valid, chk_data        - player symbol
//   chk_ok, chk_err, chk_done  - one-cycle result pulses
//   busy                       - FSM not IDLE
module sequence_store
  import sequence_store_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 16   // must be >= 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   full,
  output logic [$clog2(DEPTH):0] length,
  input  logic                   play_start,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_last,
  input  logic                   chk_start,
  input  logic                   chk_valid,
  input  logic [DATA_W-1:0]      chk_data,
  output logic                   chk_ok,
  output logic                   chk_err,
  output logic                   chk_done,
  output logic                   busy
);

  localparam int PTR_W = seq_ptr_w(DEPTH);

  state_t            state;
  logic [PTR_W-1:0]  idx;
  logic [PTR_W-1:0]  idx_nxt;
  logic [PTR_W:0]    last_pos;
  logic              at_last;
  logic              nxt_last;
  logic              wr_fire;
  logic              play_go;
  logic              chk_go;
  logic              has_data;
  logic [PTR_W-1:0]  rd_addr;
  logic [PTR_W-1:0]  ram_addr;
  logic [DATA_W-1:0] ram_rdata;

  assign idx_nxt  = idx + PTR_W'(1);
  assign last_pos = length - (PTR_W+1)'(1);
  assign at_last  = ({1'b0, idx} == last_pos);
  assign nxt_last = ({1'b0, idx_nxt} == last_pos);
  assign has_data = (length != '0);

  // A raised wr_en blocks starts in the same cycle even if the write itself
  // is dropped because the store is full: the writer owns that cycle.
  assign wr_fire = (state == IDLE) && wr_en && !full;
  assign play_go = (state == IDLE) && !wr_en && play_start && has_data;
  assign chk_go  = (state == IDLE) && !wr_en && !play_start && chk_start && has_data;

  // PLAY pre-fetches the symbol after the one currently presented so the
  // output register can advance on every accepted transfer. On the accept
  // cycle (IDLE) the address is 0, which is the first symbol to present.
  always_comb begin
    rd_addr = '0;
    case (state)
      PLAY:    rd_addr = idx_nxt;
      CHECK:   rd_addr = idx;
      default: rd_addr = '0;
    endcase
  end

  // Writes only happen in IDLE without a start, so sharing one address
  // between write and read never conflicts.
  assign ram_addr = wr_fire ? length[PTR_W-1:0] : rd_addr;

  seq_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_fire),
    .addr  (ram_addr),
    .wdata (wr_data),
    .rdata (ram_rdata)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      // clear has the same register effect as reset; only rst has priority.
      state     <= IDLE;
      idx       <= '0;
      length    <= '0;
      full      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      chk_ok    <= 1'b0;
      chk_err   <= 1'b0;
      chk_done  <= 1'b0;
    end else begin
      chk_ok   <= 1'b0;
      chk_err  <= 1'b0;
      chk_done <= 1'b0;

      case (state)
        IDLE: begin
          if (wr_fire) begin
            length <= length + (PTR_W+1)'(1);
            full   <= (length == (PTR_W+1)'(DEPTH - 1));
          end else if (play_go) begin
            state     <= PLAY;
            idx       <= '0;
            out_valid <= 1'b1;
            out_data  <= ram_rdata;
            out_last  <= (length == (PTR_W+1)'(1));
          end else if (chk_go) begin
            state <= CHECK;
            idx   <= '0;
          end
        end

        PLAY: begin
          if (out_valid && out_ready) begin
            if (out_last) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_data  <= '0;
              out_last  <= 1'b0;
            end else begin
              idx      <= idx_nxt;
              out_data <= ram_rdata;
              out_last <= nxt_last;
            end
          end
        end

        CHECK: begin
          if (chk_valid) begin
            if (chk_data == ram_rdata) begin
              chk_ok <= 1'b1;
              if (at_last) begin
                chk_done <= 1'b1;
                state    <= IDLE;
              end else begin
                idx <= idx_nxt;
              end
            end else begin
              // Mismatch abandons the rest of the sequence.
              chk_err <= 1'b1;
              state   <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_store.sv
// tb_sequence_store: directed stimulus with queue-based scoreboard for sequence_store.
// Stimulus pushes expected playback/check responses; a negedge monitor pops and compares.
// Direct checks cover status (length, full, busy) and hold-stability under backpressure.
module tb_sequence_store;

  localparam int DATA_W = 4;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              clear;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic [2:0]        length;
  logic              play_start;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              chk_start;
  logic              chk_valid;
  logic [DATA_W-1:0] chk_data;
  logic              chk_ok;
  logic              chk_err;
  logic              chk_done;
  logic              busy;

  int tests = 0;
  int fails = 0;

  // Expected playback beats: {last, data}. Expected check pulses: {ok, err, done}.
  logic [DATA_W:0] out_q[$];
  logic [2:0]      chk_q[$];

  always #5 clk = ~clk;

  sequence_store #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .length     (length),
    .play_start (play_start),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .chk_start  (chk_start),
    .chk_valid  (chk_valid),
    .chk_data   (chk_data),
    .chk_ok     (chk_ok),
    .chk_err    (chk_err),
    .chk_done   (chk_done),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample half a cycle away from the active edge.
  task automatic settle();
    @(negedge clk);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (out_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL out_unexpected: got data %0h last %0b expected no beat at %0t",
                   out_data, out_last, $time);
        end else begin
          logic [DATA_W:0] e;
          e = out_q.pop_front();
          check("out_data", 32'(out_data), 32'(e[DATA_W-1:0]));
          check("out_last", 32'(out_last), 32'(e[DATA_W]));
        end
      end
      if (chk_ok || chk_err || chk_done) begin
        if (chk_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL chk_unexpected: got ok/err/done %0b%0b%0b expected none at %0t",
                   chk_ok, chk_err, chk_done, $time);
        end else begin
          logic [2:0] c;
          c = chk_q.pop_front();
          check("chk_pulses", 32'({chk_ok, chk_err, chk_done}), 32'(c));
        end
      end
    end
  end

  logic [DATA_W-1:0] seq [4];

  initial begin
    seq[0] = 4'h3; seq[1] = 4'hA; seq[2] = 4'h5; seq[3] = 4'hC;

    rst = 1'b1; clear = 1'b0; wr_en = 1'b0; wr_data = '0;
    play_start = 1'b0; out_ready = 1'b0; chk_start = 1'b0;
    chk_valid = 1'b0; chk_data = '0;

    // 1. Reset
    tick(); tick();
    rst = 1'b0;
    settle();
    check("rst_length", 32'(length), 0);
    check("rst_full", 32'(full), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_chk_pulses", 32'({chk_ok, chk_err, chk_done}), 0);

    // 2. Append 3, A, 5, C, then an overflowing F
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = seq[i];
      tick();
      check("append_length", 32'(length), 32'(i + 1));
      check("append_full", 32'(full), (i == 3) ? 1 : 0);
    end
    wr_data = 4'hF;
    tick();
    wr_en = 1'b0;
    check("overflow_length", 32'(length), 4);
    check("overflow_full", 32'(full), 1);

    // 3. Full-throughput playback
    for (int i = 0; i < 4; i++) out_q.push_back({(i == 3), seq[i]});
    out_ready = 1'b1; play_start = 1'b1;
    tick();
    play_start = 1'b0;
    check("play_first_valid", 32'(out_valid), 1);
    check("play_busy", 32'(busy), 1);
    tick(); tick(); tick(); tick();
    check("play_end_valid", 32'(out_valid), 0);
    check("play_end_busy", 32'(busy), 0);
    check("play_end_data", 32'(out_data), 0);

    // 4. Playback with backpressure on A
    for (int i = 0; i < 4; i++) out_q.push_back({(i == 3), seq[i]});
    play_start = 1'b1;
    tick();
    play_start = 1'b0;
    tick();              // 3 transferred, A presented
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("hold_valid", 32'(out_valid), 1);
      check("hold_data", 32'(out_data), 32'hA);
      check("hold_last", 32'(out_last), 0);
      tick();
    end
    out_ready = 1'b1;
    tick(); tick(); tick();
    check("bp_end_busy", 32'(busy), 0);

    // chk_valid outside CHECK must produce no pulse
    chk_valid = 1'b1; chk_data = 4'h3;
    tick();
    chk_valid = 1'b0;
    settle();
    check("idle_chk_ignored", 32'({chk_ok, chk_err, chk_done}), 0);

    // 5. Successful check
    chk_q.push_back(3'b100); chk_q.push_back(3'b100);
    chk_q.push_back(3'b100); chk_q.push_back(3'b101);
    chk_start = 1'b1;
    tick();
    chk_start = 1'b0;
    check("chk_busy", 32'(busy), 1);
    for (int i = 0; i < 4; i++) begin
      chk_valid = 1'b1; chk_data = seq[i];
      tick();
    end
    chk_valid = 1'b0;
    check("chk_done_idle", 32'(busy), 0);
    tick();

    // Failing check: 3 then B
    chk_q.push_back(3'b100); chk_q.push_back(3'b010);
    chk_start = 1'b1;
    tick();
    chk_start = 1'b0;
    chk_valid = 1'b1; chk_data = 4'h3;
    tick();
    chk_data = 4'hB;
    tick();
    chk_valid = 1'b0;
    check("chk_err_idle", 32'(busy), 0);
    tick();

    // 6. Clear while 5 is pending
    out_q.push_back({1'b0, 4'h3}); out_q.push_back({1'b0, 4'hA});
    play_start = 1'b1; out_ready = 1'b1;
    tick();
    play_start = 1'b0;
    tick(); tick();      // 3 and A transferred, 5 presented
    out_ready = 1'b0;
    settle();
    check("pending_data", 32'(out_data), 32'h5);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_valid", 32'(out_valid), 0);
    check("clear_length", 32'(length), 0);
    check("clear_full", 32'(full), 0);
    check("clear_busy", 32'(busy), 0);
    play_start = 1'b1; out_ready = 1'b1;
    tick();
    play_start = 1'b0;
    check("empty_play_busy", 32'(busy), 0);
    check("empty_play_valid", 32'(out_valid), 0);
    wr_en = 1'b1; wr_data = 4'h7;
    tick();
    wr_en = 1'b0;
    check("rewrite_length", 32'(length), 1);
    out_q.push_back({1'b1, 4'h7});
    play_start = 1'b1;
    tick();
    play_start = 1'b0;
    check("rewrite_last", 32'(out_last), 1);
    tick();
    check("rewrite_busy", 32'(busy), 0);

    tick(); tick();
    check("out_q_drained", 32'(out_q.size()), 0);
    check("chk_q_drained", 32'(chk_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
